// File: rtl/timer_bank.sv
// Bank of independent down-counting timers with per-channel period/mode registers.
// Define TIMER_BANK_PRESCALER_EN to divide the shared count tick by PRESCALE.
module timer_bank #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int PRESCALE = 8
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 enable,
  input  logic                                 wr_en,
  input  logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] wr_ch,
  input  logic [WIDTH-1:0]                     wr_period,
  input  logic                                 wr_oneshot,
  input  logic [CHANNELS-1:0]                  start,
  input  logic [CHANNELS-1:0]                  stop,
  output logic [CHANNELS-1:0]                  zero,
  output logic [CHANNELS-1:0]                  running,
  output logic [CHANNELS*WIDTH-1:0]            count
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [CH_W:0]      CH_LIMIT = CHANNELS[CH_W:0];
  localparam logic [WIDTH-1:0]   ONE      = WIDTH'(1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("timer_bank: WIDTH out of range");
  end
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("timer_bank: CHANNELS out of range");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("timer_bank: PRESCALE must be at least 1");
  end

  logic tick;
  logic wr_ok;

  // Zero periods and out-of-range channels are dropped before they reach any channel.
  assign wr_ok = wr_en && (wr_period != '0) && ({1'b0, wr_ch} < CH_LIMIT);

`ifdef TIMER_BANK_PRESCALER_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0] presc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
    end else if (enable) begin
      presc_q <= (presc_q == PS_LAST) ? '0 : presc_q + PS_W'(1);
    end
  end

  assign tick = enable && (presc_q == PS_LAST);
`else
  assign tick = enable;
`endif

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] period_q;
    logic             oneshot_q;
    logic             zero_q;
    logic             wr_hit;

    assign wr_hit = wr_ok && (wr_ch == CH_W'(gi));

    // Start/restart reads period_q before a same-cycle write lands, so it sees the old period.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q   <= IDLE;
        count_q   <= '0;
        period_q  <= '1;
        oneshot_q <= 1'b0;
        zero_q    <= 1'b0;
      end else begin
        zero_q <= 1'b0;
        if (wr_hit) begin
          period_q  <= wr_period;
          oneshot_q <= wr_oneshot;
        end
        case (state_q)
          IDLE: begin
            if (start[gi]) begin
              count_q <= period_q - ONE;
              state_q <= RUN;
            end
          end
          RUN: begin
            if (stop[gi]) begin
              state_q <= IDLE;
            end else if (start[gi]) begin
              count_q <= period_q - ONE;
            end else if (tick) begin
              if (count_q != '0) begin
                count_q <= count_q - ONE;
              end else begin
                zero_q <= 1'b1;
                if (oneshot_q) begin
                  state_q <= IDLE;
                end else begin
                  count_q <= period_q - ONE;
                end
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end

    assign zero[gi]                   = zero_q;
    assign running[gi]                = (state_q == RUN);
    assign count[gi*WIDTH +: WIDTH]   = count_q;
  end

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank (default build, three channels so wr_ch can name a missing channel).
module tb_timer_bank;

  localparam int W  = 16;
  localparam int CH = 3;
  localparam int CW = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic              wr_en = 1'b0;
  logic [CW-1:0]     wr_ch = '0;
  logic [W-1:0]      wr_period = '0;
  logic              wr_oneshot = 1'b0;
  logic [CH-1:0]     start = '0;
  logic [CH-1:0]     stop = '0;
  logic [CH-1:0]     zero;
  logic [CH-1:0]     running;
  logic [CH*W-1:0]   count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timer_bank #(
    .WIDTH(W),
    .CHANNELS(CH),
    .PRESCALE(4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .wr_en     (wr_en),
    .wr_ch     (wr_ch),
    .wr_period (wr_period),
    .wr_oneshot(wr_oneshot),
    .start     (start),
    .stop      (stop),
    .zero      (zero),
    .running   (running),
    .count     (count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] cnt(input int ch);
    return count[ch*W +: W];
  endfunction

  task automatic wr(input int ch, input int per, input logic os);
    wr_en      = 1'b1;
    wr_ch      = CW'(ch);
    wr_period  = W'(per);
    wr_oneshot = os;
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    check("rst_zero", 32'(zero), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    for (int i = 0; i < CH; i++) check($sformatf("rst_count%0d", i), 32'(cnt(i)), 32'd0);
    reset_n = 1'b1;
    step();

    // Periodic ch0, period 5
    wr(0, 5, 1'b0);
    start  = 3'b001;
    enable = 1'b1;
    step();
    start = '0;
    check("A_start_cnt", 32'(cnt(0)), 32'd4);
    check("A_start_run", 32'(running[0]), 32'd1);
    for (int k = 1; k <= 15; k++) begin
      step();
      check($sformatf("A_cnt_k%0d", k), 32'(cnt(0)), (k % 5 == 0) ? 32'd4 : 32'(4 - (k % 5)));
      check($sformatf("A_zero_k%0d", k), 32'(zero[0]), (k % 5 == 0) ? 32'd1 : 32'd0);
    end

    // No tick: hold
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("hold_cnt", 32'(cnt(0)), 32'd4);
      check("hold_zero", 32'(zero[0]), 32'd0);
    end
    enable = 1'b1;
    step();
    check("resume_cnt", 32'(cnt(0)), 32'd3);
    stop = 3'b001;
    step();
    stop = '0;
    check("stop_run", 32'(running[0]), 32'd0);
    check("stop_cnt", 32'(cnt(0)), 32'd3);
    step();
    check("stop_hold_cnt", 32'(cnt(0)), 32'd3);

    // One-shot ch1, period 3
    wr(1, 3, 1'b1);
    start = 3'b010;
    step();
    start = '0;
    check("B_start_cnt", 32'(cnt(1)), 32'd2);
    check("B_start_run", 32'(running[1]), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("B_cnt_k%0d", k), 32'(cnt(1)), (k >= 2) ? 32'd0 : 32'(2 - k));
      check($sformatf("B_zero_k%0d", k), 32'(zero[1]), (k == 3) ? 32'd1 : 32'd0);
      check($sformatf("B_run_k%0d", k), 32'(running[1]), (k < 3) ? 32'd1 : 32'd0);
    end

    // Start and stop together at count 2: stop wins
    start = 3'b001;
    step();
    start = '0;
    check("C_start_cnt", 32'(cnt(0)), 32'd4);
    repeat (2) step();
    check("C_cnt2", 32'(cnt(0)), 32'd2);
    start = 3'b001;
    stop  = 3'b001;
    step();
    start = '0;
    stop  = '0;
    check("C_run", 32'(running[0]), 32'd0);
    check("C_cnt", 32'(cnt(0)), 32'd2);
    check("C_zero", 32'(zero[0]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("C_hold_cnt", 32'(cnt(0)), 32'd2);
      check("C_hold_zero", 32'(zero[0]), 32'd0);
    end

    // Ignored writes: zero period, nonexistent channel
    wr(2, 0, 1'b1);
    wr(3, 7, 1'b1);
    start = 3'b111;
    step();
    start = '0;
    check("D_cnt2_default", 32'(cnt(2)), 32'h0000_fffe);
    check("D_cnt0", 32'(cnt(0)), 32'd4);
    check("D_cnt1", 32'(cnt(1)), 32'd2);
    check("D_running", 32'(running), 32'b111);
    stop = 3'b111;
    step();
    stop = '0;
    check("D_stopped", 32'(running), 32'd0);

    // Write + start same cycle: start uses old period, reload uses new
    wr_en      = 1'b1;
    wr_ch      = 2'd0;
    wr_period  = 16'd9;
    wr_oneshot = 1'b0;
    start      = 3'b001;
    step();
    wr_en = 1'b0;
    start = '0;
    check("E_start_cnt", 32'(cnt(0)), 32'd4);
    for (int k = 1; k <= 5; k++) begin
      step();
      check($sformatf("E_cnt_k%0d", k), 32'(cnt(0)), (k < 5) ? 32'(4 - k) : 32'd8);
      check($sformatf("E_zero_k%0d", k), 32'(zero[0]), (k == 5) ? 32'd1 : 32'd0);
    end

    // Reset at count 1
    repeat (7) step();
    check("R_pre_cnt", 32'(cnt(0)), 32'd1);
    reset_n = 1'b0;
    #1;
    check("R_cnt", 32'(cnt(0)), 32'd0);
    check("R_run", 32'(running), 32'd0);
    check("R_zero", 32'(zero), 32'd0);
    repeat (2) step();
    reset_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      check("R_post_zero", 32'(zero), 32'd0);
      check("R_post_run", 32'(running), 32'd0);
    end
    start = 3'b001;
    step();
    start = '0;
    check("R_period_reset", 32'(cnt(0)), 32'h0000_fffe);

    // Period 1 on ch1: zero every tick
    wr(1, 1, 1'b0);
    start = 3'b010;
    step();
    start = '0;
    check("P1_start_cnt", 32'(cnt(1)), 32'd0);
    check("P1_start_zero", 32'(zero[1]), 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("P1_zero_k%0d", k), 32'(zero[1]), 32'd1);
      check($sformatf("P1_cnt_k%0d", k), 32'(cnt(1)), 32'd0);
      check($sformatf("P1_run_k%0d", k), 32'(running[1]), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 Parameter WIDTH, default 16, bit width of each channel's period and count (2..32).
REQ-002 Parameter CHANNELS, default 4, number of independent down-counting channels (1..16).
REQ-003 Parameter PRESCALE, default 8, shared tick divide ratio (>=1); used only when TIMER_BANK_PRESCALER_EN is defined.
REQ-004 clk  input  1  clock, rising-edge active.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  global count enable; no channel counts while low.
REQ-007 wr_en  input  1  period/mode write strobe, sampled each clk.
REQ-008 wr_ch  input  max(1,$clog2(CHANNELS))  target channel of the write.
REQ-009 wr_period  input  WIDTH  period value to store.
REQ-010 wr_oneshot  input  1  mode to store: 1 = one-shot, 0 = periodic.
REQ-011 start  input  CHANNELS  per-channel start/restart request, bit i for channel i.
REQ-012 stop  input  CHANNELS  per-channel stop request.
REQ-013 zero  output  CHANNELS  registered one-clk pulse at each channel terminal count.
REQ-014 running  output  CHANNELS  high while channel in RUN state.
REQ-015 count  output  CHANNELS*WIDTH  current count; channel i at bits [i*WIDTH +: WIDTH].

Function
REQ-016 tick = enable (macro absent) or enable AND prescaler wrap (macro present); all counting uses tick.
REQ-017 Per-channel FSM, two states: IDLE, RUN.
REQ-018 IDLE + start[i]: count <= period-1, state RUN; tick not required.
REQ-019 RUN + stop[i]: state IDLE, count held, no zero pulse; stop wins over start and terminal count in same cycle.
REQ-020 RUN + start[i] (no stop): restart, count <= period-1, no zero pulse that cycle.
REQ-021 RUN + tick + count!=0: count decrements by 1.
REQ-022 RUN + tick + count==0: zero[i] high next cycle for exactly one clk; periodic -> count <= period-1, stay RUN; one-shot -> state IDLE, count stays 0.
REQ-023 Periodic channel with enable held high: zero pulses every period clks; first pulse period clks after the start edge.
REQ-024 Without tick, count, state and zero hold (zero low).
REQ-025 Write with wr_en=1 updates period and mode of channel wr_ch at next edge.
REQ-026 Writes with wr_period==0 or wr_ch>=CHANNELS are ignored entirely.
REQ-027 Write to a RUN channel does not disturb count; new period applies at next reload or start.
REQ-028 Write and start to same channel in same cycle: start uses the old period.
REQ-029 Period value 1: zero pulses every tick (count stays 0 on reload).
REQ-030 Channels fully independent; any combination of simultaneous start/stop/terminal events is legal.

Reset
REQ-031 On reset_n low, asynchronously: all states IDLE, count = 0, zero = 0, running = 0, prescaler = 0.
REQ-032 On reset, each period register = all ones ({WIDTH{1}}), each mode = periodic.
REQ-033 Reset mid-count aborts any pending zero pulse; no pulse follows reset release without a new start.

Configuration
REQ-034 Macro TIMER_BANK_PRESCALER_EN defined: shared counter 0..PRESCALE-1 advances on enable; wrap sets tick; PRESCALE=1 equals tick=enable.
REQ-035 Macro absent: no prescaler logic; tick = enable; PRESCALE ignored.

Verification
REQ-036 Write ch0 period=5 periodic, start[0], enable=1 -> zero[0] high at start edge+5, +10, +15; count[0] 4,3,2,1,0,4...
REQ-037 Write ch1 period=3 one-shot, start[1] -> single zero[1] pulse 3 clks after start; running[1] falls with pulse; count[1]=0.
REQ-038 ch0 running at count=2: assert start[0] and stop[0] together -> IDLE, count[0] holds 2, no zero pulse.
REQ-039 Write wr_period=0 to ch2, then wr_ch=CHANNELS (CHANNELS<2^width) -> ch2 period stays all ones; no channel changes.
REQ-040 Assert reset_n low while ch0 count=1 -> all outputs 0 immediately; no zero pulse after release.
REQ-041 With TIMER_BANK_PRESCALER_EN, PRESCALE=4, period=2, enable=1 -> zero[0] every 8 clks.
